// File: rtl/multicycle_controller.sv
// Moore control FSM with ALU and immediate-format decoders for a multicycle RISC-V core.
// Defining MULTICYCLE_CTRL_JALR_EN adds the two JALR states; otherwise op 1100111 decodes as an illegal opcode.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       InstrDone
);

`ifdef MULTICYCLE_CTRL_JALR_EN
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALRWB
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write_c, reg_write_c, mem_write_c, done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BEQ;
`ifdef MULTICYCLE_CTRL_JALR_EN
          7'b1100111:             state_d = S_JALR;
`endif
          // Unknown opcode retires right here as a two-cycle nop.
          default: begin
            state_d = S_FETCH;
            done_c  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        done_c  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef MULTICYCLE_CTRL_JALR_EN
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // Reset squashes strobes combinationally so a write in flight is killed in its own cycle.
  assign IRWrite   = ir_write_c & ~reset;
  assign PCWrite   = (pc_update | (branch & Zero)) & ~reset;
  assign RegWrite  = reg_write_c & ~reset;
  assign MemWrite  = mem_write_c & ~reset;
  assign InstrDone = done_c & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors go into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] imm;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic       adr;
    logic [2:0] aluc;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       done;
  } exp_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ILL  = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, InstrDone;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

  function automatic exp_t ev(input logic [1:0] imm, input logic [1:0] asa, input logic [1:0] asb,
                              input logic [1:0] rs, input logic adr, input logic [2:0] aluc,
                              input logic irw, input logic pcw, input logic rw, input logic mw,
                              input logic done);
    exp_t e;
    e = '{imm: imm, asa: asa, asb: asb, rs: rs, adr: adr, aluc: aluc,
          irw: irw, pcw: pcw, rw: rw, mw: mw, done: done};
    return e;
  endfunction

  // FETCH, DECODE and held-in-reset vectors with ImmSrc supplied by the caller.
  function automatic exp_t vf(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t vd(input logic [1:0] imm, input logic done);
    return ev(imm, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, done);
  endfunction
  function automatic exp_t vr(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Called just after a rising edge: drive one cycle's inputs and queue its expected outputs.
  task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input exp_t e, input string nm);
    reset    = rst;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  exp_t  mon_exp, mon_act;
  string mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = '{imm: ImmSrc, asa: ALUSrcA, asb: ALUSrcB, rs: ResultSrc, adr: AdrSrc,
                  aluc: ALUControl, irw: IRWrite, pcw: PCWrite, rw: RegWrite, mw: MemWrite,
                  done: InstrDone};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (imm asa asb rs adr aluc irw pcw rw mw done)",
                 mon_nm, mon_act, mon_exp);
      end
    end
  end

  initial begin
    reset = 1'b1; op = SW; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, SW, 3'd0, 0, 0, vr(2'd1), "reset_hold");

    // lw: 5 cycles
    cyc(0, LW, 3'd2, 0, 0, vf(2'd0), "lw_fetch");
    cyc(0, LW, 3'd2, 0, 0, vd(2'd0, 0), "lw_decode");
    cyc(0, LW, 3'd2, 0, 0, ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw_memadr");
    cyc(0, LW, 3'd2, 0, 0, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "lw_memread");
    cyc(0, LW, 3'd2, 0, 0, ev(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1), "lw_memwb");

    // beq taken then not taken; Zero held high through DECODE must not write PC
    cyc(0, BEQ, 3'd0, 0, 1, vf(2'd2), "beq1_fetch");
    cyc(0, BEQ, 3'd0, 0, 1, vd(2'd2, 0), "beq1_decode");
    cyc(0, BEQ, 3'd0, 0, 1, ev(2, 2, 0, 0, 0, 1, 0, 1, 0, 0, 1), "beq1_taken");
    cyc(0, BEQ, 3'd0, 0, 0, vf(2'd2), "beq0_fetch");
    cyc(0, BEQ, 3'd0, 0, 0, vd(2'd2, 0), "beq0_decode");
    cyc(0, BEQ, 3'd0, 0, 0, ev(2, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1), "beq0_not_taken");

    // R-type sub / add, I-type addi with funct7b5 set
    cyc(0, RT, 3'd0, 1, 0, vf(2'd0), "sub_fetch");
    cyc(0, RT, 3'd0, 1, 0, vd(2'd0, 0), "sub_decode");
    cyc(0, RT, 3'd0, 1, 0, ev(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0), "sub_execr");
    cyc(0, RT, 3'd0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "sub_aluwb");
    cyc(0, RT, 3'd0, 0, 0, vf(2'd0), "add_fetch");
    cyc(0, RT, 3'd0, 0, 0, vd(2'd0, 0), "add_decode");
    cyc(0, RT, 3'd0, 0, 0, ev(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_execr");
    cyc(0, RT, 3'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "add_aluwb");
    cyc(0, IT, 3'd0, 1, 0, vf(2'd0), "addi_fetch");
    cyc(0, IT, 3'd0, 1, 0, vd(2'd0, 0), "addi_decode");
    cyc(0, IT, 3'd0, 1, 0, ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "addi_execi");
    cyc(0, IT, 3'd0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "addi_aluwb");

    // remaining funct3 decodes, checked in the execute state
    cyc(0, RT, 3'd6, 0, 0, vf(2'd0), "or_fetch");
    cyc(0, RT, 3'd6, 0, 0, vd(2'd0, 0), "or_decode");
    cyc(0, RT, 3'd6, 0, 0, ev(0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0), "or_execr");
    cyc(0, RT, 3'd6, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "or_aluwb");
    cyc(0, IT, 3'd7, 0, 0, vf(2'd0), "andi_fetch");
    cyc(0, IT, 3'd7, 0, 0, vd(2'd0, 0), "andi_decode");
    cyc(0, IT, 3'd7, 0, 0, ev(0, 2, 1, 0, 0, 2, 0, 0, 0, 0, 0), "andi_execi");
    cyc(0, IT, 3'd7, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "andi_aluwb");
    cyc(0, IT, 3'd2, 0, 0, vf(2'd0), "slti_fetch");
    cyc(0, IT, 3'd2, 0, 0, vd(2'd0, 0), "slti_decode");
    cyc(0, IT, 3'd2, 0, 0, ev(0, 2, 1, 0, 0, 5, 0, 0, 0, 0, 0), "slti_execi");
    cyc(0, IT, 3'd2, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "slti_aluwb");
    cyc(0, RT, 3'd1, 1, 0, vf(2'd0), "sll_fetch");
    cyc(0, RT, 3'd1, 1, 0, vd(2'd0, 0), "sll_decode");
    cyc(0, RT, 3'd1, 1, 0, ev(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sll_execr_add");
    cyc(0, RT, 3'd1, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "sll_aluwb");

    // sw then illegal opcode
    cyc(0, SW, 3'd2, 0, 0, vf(2'd1), "sw_fetch");
    cyc(0, SW, 3'd2, 0, 0, vd(2'd1, 0), "sw_decode");
    cyc(0, SW, 3'd2, 0, 0, ev(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw_memadr");
    cyc(0, SW, 3'd2, 0, 0, ev(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1), "sw_memwrite");
    cyc(0, ILL, 3'd0, 0, 0, vf(2'd0), "ill_fetch");
    cyc(0, ILL, 3'd0, 0, 0, vd(2'd0, 1), "ill_decode_done");

    // jal
    cyc(0, JAL, 3'd0, 0, 0, vf(2'd3), "jal_fetch");
    cyc(0, JAL, 3'd0, 0, 0, vd(2'd3, 0), "jal_decode");
    cyc(0, JAL, 3'd0, 0, 0, ev(3, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0), "jal_jal");
    cyc(0, JAL, 3'd0, 0, 0, ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "jal_aluwb");

    // jalr: 4 cycles with the option, 2-cycle nop without
    cyc(0, JALR, 3'd0, 0, 0, vf(2'd0), "jalr_fetch");
`ifdef MULTICYCLE_CTRL_JALR_EN
    cyc(0, JALR, 3'd0, 0, 0, vd(2'd0, 0), "jalr_decode");
    cyc(0, JALR, 3'd0, 0, 0, ev(0, 2, 1, 2, 0, 0, 0, 1, 0, 0, 0), "jalr_jalr");
    cyc(0, JALR, 3'd0, 0, 0, ev(0, 1, 2, 2, 0, 0, 0, 0, 1, 0, 1), "jalr_jalrwb");
`else
    cyc(0, JALR, 3'd0, 0, 0, vd(2'd0, 1), "jalr_decode_nop");
`endif

    // reset lands on the MEMWRITE cycle of a sw, then a clean fetch
    cyc(0, SW, 3'd2, 0, 0, vf(2'd1), "swrst_fetch");
    cyc(0, SW, 3'd2, 0, 0, vd(2'd1, 0), "swrst_decode");
    cyc(0, SW, 3'd2, 0, 0, ev(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "swrst_memadr");
    cyc(1, SW, 3'd2, 0, 0, vr(2'd1), "swrst_reset_in_memwrite");
    cyc(1, SW, 3'd2, 0, 0, vr(2'd1), "swrst_reset_hold");
    cyc(0, LW, 3'd2, 0, 0, vf(2'd0), "post_rst_fetch");
    cyc(0, LW, 3'd2, 0, 0, vd(2'd0, 0), "post_rst_decode");
    cyc(0, LW, 3'd2, 0, 0, ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_memadr");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
